// File: rtl/multicycle_control.sv
// Main multicycle control FSM: decodes the opcode and steps each instruction through its states.
// Latency: one state per clock; FETCH, MEMRD and MEMWR are each held for 1+MEM_WAIT cycles.
// Backpressure: none accepted; memory latency is absorbed only through the fixed MEM_WAIT hold.
module multicycle_control #(
   parameter int MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   output logic       aluop1,
   output logic       aluop0,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       pcsource,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       illegal,
   output logic [3:0] state_o
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SUBI = 6'b001001;

   // Count value at which a memory state has been held long enough.
   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_REXEC  = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [3:0] wait_cnt;
   logic       subi_flag;
   logic       wait_done;
   logic [1:0] aluop;

   assign wait_done = (wait_cnt == WAIT_LAST);
   assign aluop1    = aluop[1];
   assign aluop0    = aluop[0];
   assign state_o   = state;

   // State register, memory wait counter and subi flag; the counter restarts on every state change.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RST;
         wait_cnt  <= 4'd0;
         subi_flag <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state != state)
            wait_cnt <= 4'd0;
         else
            wait_cnt <= wait_cnt + 4'd1;
         if (state == S_DECODE)
            subi_flag <= (op == OP_SUBI);
      end
   end

   // Next-state and Moore output decode; everything defaults to 0 and to holding the state.
   always_comb begin
      next_state  = state;
      aluop       = 2'b00;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      pcsource    = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      illegal     = 1'b0;
      case (state)
         S_RST: begin
            next_state = S_FETCH;
         end
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            // IR and PC load only once the memory word is valid.
            if (wait_done) begin
               irwrite    = 1'b1;
               pcwrite    = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW:      next_state = S_MEMADR;
               OP_R:              next_state = S_REXEC;
               OP_BEQ:            next_state = S_BRANCH;
               OP_ADDI, OP_SUBI:  next_state = S_IEXEC;
               default: begin
                  illegal    = 1'b1;
                  next_state = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
            if (wait_done)
               next_state = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite   = 1'b1;
            memtoreg   = 1'b1;
            next_state = S_FETCH;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
            if (wait_done)
               next_state = S_FETCH;
         end
         S_REXEC: begin
            alusrca    = 1'b1;
            aluop      = 2'b10;
            next_state = S_RWB;
         end
         S_RWB: begin
            regwrite   = 1'b1;
            regdst     = 1'b1;
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            alusrca     = 1'b1;
            aluop       = 2'b01;
            pcwritecond = 1'b1;
            pcsource    = 1'b1;
            next_state  = S_FETCH;
         end
         S_IEXEC: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            aluop      = subi_flag ? 2'b01 : 2'b00;
            next_state = S_IWB;
         end
         S_IWB: begin
            regwrite   = 1'b1;
            next_state = S_FETCH;
         end
         // Unused codes recover straight to FETCH with all outputs low.
         default: begin
            next_state = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (MEM_WAIT 0 and 2) share clk/rst/op.
// Expected per-cycle outputs come from an instruction-level model expanding each opcode into its cycle list.
// One instance is observed at a time, selected by sel; switching always goes through a reset.
module tb_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SUBI = 6'b001001;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   // Observation vector layout: state[19:16] aluop[15:14] srca[13] srcb[12:11] then single-bit flags.
   typedef logic [19:0] vec_t;
   localparam vec_t F_PCW  = 20'h00400;
   localparam vec_t F_PWC  = 20'h00200;
   localparam vec_t F_PCS  = 20'h00100;
   localparam vec_t F_IORD = 20'h00080;
   localparam vec_t F_MR   = 20'h00040;
   localparam vec_t F_MW   = 20'h00020;
   localparam vec_t F_IRW  = 20'h00010;
   localparam vec_t F_RD   = 20'h00008;
   localparam vec_t F_M2R  = 20'h00004;
   localparam vec_t F_RW   = 20'h00002;
   localparam vec_t F_ILL  = 20'h00001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op  = 6'd0;
   int         sel = 0;

   logic [1:0] aluop1_w, aluop0_w, alusrca_w, pcwrite_w, pcwritecond_w, pcsource_w;
   logic [1:0] iord_w, memread_w, memwrite_w, irwrite_w, regdst_w, memtoreg_w, regwrite_w, illegal_w;
   logic [1:0] alusrcb_w [2];
   logic [3:0] state_w [2];

   int total = 0;
   int bad   = 0;
   vec_t exp_q[$];

   always #5 clk = ~clk;

   multicycle_control #(.MEM_WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .op(op),
      .aluop1(aluop1_w[0]), .aluop0(aluop0_w[0]), .alusrca(alusrca_w[0]), .alusrcb(alusrcb_w[0]),
      .pcwrite(pcwrite_w[0]), .pcwritecond(pcwritecond_w[0]), .pcsource(pcsource_w[0]),
      .iord(iord_w[0]), .memread(memread_w[0]), .memwrite(memwrite_w[0]), .irwrite(irwrite_w[0]),
      .regdst(regdst_w[0]), .memtoreg(memtoreg_w[0]), .regwrite(regwrite_w[0]),
      .illegal(illegal_w[0]), .state_o(state_w[0])
   );

   multicycle_control #(.MEM_WAIT(2)) dut2 (
      .clk(clk), .rst(rst), .op(op),
      .aluop1(aluop1_w[1]), .aluop0(aluop0_w[1]), .alusrca(alusrca_w[1]), .alusrcb(alusrcb_w[1]),
      .pcwrite(pcwrite_w[1]), .pcwritecond(pcwritecond_w[1]), .pcsource(pcsource_w[1]),
      .iord(iord_w[1]), .memread(memread_w[1]), .memwrite(memwrite_w[1]), .irwrite(irwrite_w[1]),
      .regdst(regdst_w[1]), .memtoreg(memtoreg_w[1]), .regwrite(regwrite_w[1]),
      .illegal(illegal_w[1]), .state_o(state_w[1])
   );

   function automatic vec_t obs();
      int i;
      i = sel;
      return {state_w[i], aluop1_w[i], aluop0_w[i], alusrca_w[i], alusrcb_w[i],
              pcwrite_w[i], pcwritecond_w[i], pcsource_w[i], iord_w[i], memread_w[i],
              memwrite_w[i], irwrite_w[i], regdst_w[i], memtoreg_w[i], regwrite_w[i], illegal_w[i]};
   endfunction

   function automatic vec_t mk(logic [3:0] st, logic [1:0] aop, logic srca, logic [1:0] srcb, vec_t flags);
      return {st, aop, srca, srcb, 11'd0} | flags;
   endfunction

   task automatic check_vec(string name, vec_t got, vec_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s t=%0t got=%05h want=%05h", name, $time, got, want);
      end
   endtask

   task automatic check_int(string name, int got, int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // Instruction-level reference: the cycle list an opcode produces at memory wait w.
   task automatic build(logic [5:0] o, int w);
      vec_t dec;
      exp_q.delete();
      for (int i = 0; i <= w; i++)
         exp_q.push_back(mk(4'd1, 2'b00, 1'b0, 2'b01, F_MR | ((i == w) ? (F_IRW | F_PCW) : 20'd0)));
      dec = mk(4'd2, 2'b00, 1'b0, 2'b11, 20'd0);
      case (o)
         OP_R: begin
            exp_q.push_back(dec);
            exp_q.push_back(mk(4'd7, 2'b10, 1'b1, 2'b00, 20'd0));
            exp_q.push_back(mk(4'd8, 2'b00, 1'b0, 2'b00, F_RD | F_RW));
         end
         OP_LW: begin
            exp_q.push_back(dec);
            exp_q.push_back(mk(4'd3, 2'b00, 1'b1, 2'b10, 20'd0));
            for (int i = 0; i <= w; i++) exp_q.push_back(mk(4'd4, 2'b00, 1'b0, 2'b00, F_MR | F_IORD));
            exp_q.push_back(mk(4'd5, 2'b00, 1'b0, 2'b00, F_M2R | F_RW));
         end
         OP_SW: begin
            exp_q.push_back(dec);
            exp_q.push_back(mk(4'd3, 2'b00, 1'b1, 2'b10, 20'd0));
            for (int i = 0; i <= w; i++) exp_q.push_back(mk(4'd6, 2'b00, 1'b0, 2'b00, F_MW | F_IORD));
         end
         OP_BEQ: begin
            exp_q.push_back(dec);
            exp_q.push_back(mk(4'd9, 2'b01, 1'b1, 2'b00, F_PWC | F_PCS));
         end
         OP_ADDI, OP_SUBI: begin
            exp_q.push_back(dec);
            exp_q.push_back(mk(4'd10, (o == OP_SUBI) ? 2'b01 : 2'b00, 1'b1, 2'b10, 20'd0));
            exp_q.push_back(mk(4'd11, 2'b00, 1'b0, 2'b00, F_RW));
         end
         default: exp_q.push_back(mk(4'd2, 2'b00, 1'b0, 2'b11, F_ILL));
      endcase
   endtask

   // Entered at a negedge in the first FETCH cycle; compares limit cycles (all when negative),
   // and when cpi_want is non-negative also checks the cycles taken to return to FETCH.
   task automatic run_instr(string name, logic [5:0] o, int cpi_want, int limit);
      int n;
      int w;
      int left;
      int cpi;
      w    = (sel == 1) ? 2 : 0;
      op   = o;
      build(o, w);
      n    = 0;
      left = 0;
      cpi  = -1;
      foreach (exp_q[k]) begin
         if (limit >= 0 && k >= limit) break;
         if (obs() >> 16 != 20'd1) left = 1;
         else if (left != 0 && cpi < 0) cpi = n;
         check_vec($sformatf("%s cyc%0d", name, k), obs(), exp_q[k]);
         n++;
         @(negedge clk);
      end
      if (cpi_want >= 0) begin
         if (left != 0 && cpi < 0 && (obs() >> 16) == 20'd1) cpi = n;
         check_int($sformatf("%s cpi", name), cpi, cpi_want);
      end
   endtask

   task automatic do_reset(int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check_vec("reset outputs", obs(), 20'd0);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic [5:0] op;
      int         sel;
      int         cpi;
   } rec_t;

   initial begin
      rec_t tbl[14];
      logic [5:0] legal[6];
      tbl[0]  = '{OP_R,    0, 4};
      tbl[1]  = '{OP_BEQ,  0, 3};
      tbl[2]  = '{OP_LW,   0, 5};
      tbl[3]  = '{OP_SW,   0, 4};
      tbl[4]  = '{OP_SUBI, 0, 4};
      tbl[5]  = '{OP_ADDI, 0, 4};
      tbl[6]  = '{OP_BAD,  0, 2};
      tbl[7]  = '{OP_R,    1, 6};
      tbl[8]  = '{OP_LW,   1, 9};
      tbl[9]  = '{OP_SW,   1, 8};
      tbl[10] = '{OP_BEQ,  1, 5};
      tbl[11] = '{OP_SUBI, 1, 6};
      tbl[12] = '{OP_ADDI, 1, 6};
      tbl[13] = '{OP_BAD,  1, 4};
      legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SUBI};

      // Reset for two cycles, then directed table.
      sel = 0;
      do_reset(2);
      foreach (tbl[i]) begin
         if (tbl[i].sel != sel) begin
            sel = tbl[i].sel;
            do_reset(1);
         end
         run_instr($sformatf("tbl%0d op=%b", i, tbl[i].op), tbl[i].op, tbl[i].cpi, -1);
      end

      // Reset in the middle of a MEM_WAIT=2 store: no further memwrite, RST then FETCH.
      sel = 1;
      do_reset(1);
      run_instr("sw abort", OP_SW, -1, 6);
      check_vec("sw abort in MEMWR", obs() & (F_MW | 20'hF0000), F_MW | 20'h60000);
      rst = 1'b1;
      @(negedge clk);
      check_vec("sw abort reset", obs(), 20'd0);
      rst = 1'b0;
      @(negedge clk);
      run_instr("after abort", OP_R, 6, -1);

      // Random instruction streams on both instances.
      for (int s = 0; s < 2; s++) begin
         sel = s;
         do_reset(1);
         for (int i = 0; i < 40; i++) begin
            logic [5:0] o;
            int r;
            r = $urandom_range(0, 6);
            if (r == 6) o = 6'($urandom);
            else o = legal[r];
            run_instr($sformatf("rnd s%0d i%0d op=%b", s, i, o), o, -1, -1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
